polygon_loader: RTL and testbench

Producer side of the polygon interface consumed by the point-in-polygon tester. On request it reads one polygon record from a vertex memory, assembles the vertex arrays in a shadow buffer, then commits them atomically to its outputs. The committed `poly_xs_out`/`poly_ys_out`/`num_points_out` wire directly to the tester's polygon inputs and stay stable while a new load is in progress.

---
 rtl/polygon_loader.sv | 188 ++++++++++++++++++
 tb/tb_polygon_loader.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/polygon_loader.sv
// Polygon record loader: fetches header + vertices from a latency-L vertex memory
// into a shadow buffer, then commits the whole polygon to its outputs in one cycle.
module polygon_loader #(
    parameter int WORLD_BITS       = 32,
    parameter int MAX_NUM_VERTICES = 32,
    parameter int ADDR_BITS        = 10,
    parameter int MEM_LATENCY      = 2
) (
    input  logic                                        clk_in,
    input  logic                                        rst_in,
    input  logic                                        start_in,
    input  logic [ADDR_BITS-1:0]                        base_addr_in,
    output logic [ADDR_BITS-1:0]                        mem_addr_out,
    output logic                                        mem_re_out,
    input  logic [2*WORLD_BITS-1:0]                     mem_data_in,
    output logic signed [WORLD_BITS-1:0]                poly_xs_out [MAX_NUM_VERTICES],
    output logic signed [WORLD_BITS-1:0]                poly_ys_out [MAX_NUM_VERTICES],
    output logic [$clog2(MAX_NUM_VERTICES+1)-1:0]       num_points_out,
    output logic                                        valid_out,
    output logic                                        busy_out,
    output logic                                        done_out,
    output logic                                        error_out
);

    localparam int CNT_W = $clog2(MAX_NUM_VERTICES + 1);
    localparam int IDX_W = (MAX_NUM_VERTICES > 1) ? $clog2(MAX_NUM_VERTICES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_FETCH,
        S_DRAIN,
        S_COMMIT,
        S_ERROR
    } state_t;

    // Tag travelling alongside each outstanding read so returning data knows its slot.
    typedef struct packed {
        logic             valid;
        logic             hdr;
        logic [IDX_W-1:0] idx;
    } tag_t;

    state_t                       state;
    logic [ADDR_BITS-1:0]         base_q;
    logic [CNT_W-1:0]             n_q;
    logic [IDX_W-1:0]             last_idx_q;
    logic [IDX_W-1:0]             issue_idx_q;
    logic                         issue_hdr_q;
    tag_t                         inflight [MEM_LATENCY];
    logic signed [WORLD_BITS-1:0] shadow_xs [MAX_NUM_VERTICES];
    logic signed [WORLD_BITS-1:0] shadow_ys [MAX_NUM_VERTICES];

    tag_t                         ret;
    logic signed [WORLD_BITS-1:0] ret_x;
    logic signed [WORLD_BITS-1:0] ret_y;
    logic [WORLD_BITS-1:0]        hdr_count;
    logic                         hdr_ok;
    logic                         ret_last;

    assign ret       = inflight[MEM_LATENCY-1];
    assign ret_x     = mem_data_in[2*WORLD_BITS-1:WORLD_BITS];
    assign ret_y     = mem_data_in[WORLD_BITS-1:0];
    assign hdr_count = mem_data_in[WORLD_BITS-1:0];
    assign hdr_ok    = (hdr_count >= WORLD_BITS'(3)) &&
                       (hdr_count <= WORLD_BITS'(MAX_NUM_VERTICES));
    assign ret_last  = ret.valid && !ret.hdr && (ret.idx == last_idx_q);

    // NOTE: the shadow buffer is plain storage rewritten before every commit, so it has no reset.
    always_ff @(posedge clk_in) begin
        if (ret.valid && !ret.hdr) begin
            shadow_xs[ret.idx] <= ret_x;
            shadow_ys[ret.idx] <= ret_y;
        end
    end

    // NOTE: all state uses <= so every register updates from pre-edge values in lockstep.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= S_IDLE;
            base_q         <= '0;
            n_q            <= '0;
            last_idx_q     <= '0;
            issue_idx_q    <= '0;
            issue_hdr_q    <= 1'b0;
            mem_addr_out   <= '0;
            mem_re_out     <= 1'b0;
            num_points_out <= '0;
            valid_out      <= 1'b0;
            busy_out       <= 1'b0;
            done_out       <= 1'b0;
            error_out      <= 1'b0;
            for (int k = 0; k < MEM_LATENCY; k++) inflight[k] <= '0;
            for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
                poly_xs_out[i] <= '0;
                poly_ys_out[i] <= '0;
            end
        end else begin
            done_out   <= 1'b0;
            error_out  <= 1'b0;
            mem_re_out <= 1'b0;

            inflight[0] <= {mem_re_out, issue_hdr_q, issue_idx_q};
            for (int k = 1; k < MEM_LATENCY; k++) inflight[k] <= inflight[k-1];

            unique case (state)
                S_IDLE: begin
                    if (start_in) begin
                        base_q       <= base_addr_in;
                        mem_addr_out <= base_addr_in;
                        mem_re_out   <= 1'b1;
                        issue_hdr_q  <= 1'b1;
                        busy_out     <= 1'b1;
                        state        <= S_HEADER;
                    end
                end

                S_HEADER: begin
                    if (ret.valid && ret.hdr) begin
                        if (hdr_ok) begin
                            n_q          <= CNT_W'(hdr_count);
                            last_idx_q   <= IDX_W'(hdr_count - WORLD_BITS'(1));
                            mem_addr_out <= base_q + 1'b1;
                            mem_re_out   <= 1'b1;
                            issue_hdr_q  <= 1'b0;
                            issue_idx_q  <= '0;
                            state        <= S_FETCH;
                        end else begin
                            error_out <= 1'b1;
                            state     <= S_ERROR;
                        end
                    end
                end

                S_FETCH: begin
                    if (issue_idx_q == last_idx_q) begin
                        state <= S_DRAIN;
                    end else begin
                        mem_addr_out <= mem_addr_out + 1'b1;
                        issue_idx_q  <= issue_idx_q + 1'b1;
                        mem_re_out   <= 1'b1;
                    end
                end

                // Outputs load on the edge entering COMMIT so they are visible with done_out;
                // the final vertex is taken straight from the memory bus as it lands.
                S_DRAIN: begin
                    if (ret_last) begin
                        for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
                            if (CNT_W'(i) < n_q) begin
                                if (ret.idx == IDX_W'(i)) begin
                                    poly_xs_out[i] <= ret_x;
                                    poly_ys_out[i] <= ret_y;
                                end else begin
                                    poly_xs_out[i] <= shadow_xs[i];
                                    poly_ys_out[i] <= shadow_ys[i];
                                end
                            end else begin
                                poly_xs_out[i] <= '0;
                                poly_ys_out[i] <= '0;
                            end
                        end
                        num_points_out <= n_q;
                        valid_out      <= 1'b1;
                        done_out       <= 1'b1;
                        state          <= S_COMMIT;
                    end
                end

                S_COMMIT: begin
                    busy_out <= 1'b0;
                    state    <= S_IDLE;
                end

                S_ERROR: begin
                    busy_out <= 1'b0;
                    state    <= S_IDLE;
                end

                default: begin
                    busy_out <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_polygon_loader.sv
// Scoreboard bench for polygon_loader: driver pushes expected reads/commits,
// a negedge monitor pops and compares against a memory-backed reference model.
module tb_polygon_loader;

    localparam int W    = 32;
    localparam int MAXV = 32;
    localparam int AB   = 10;
    localparam int L    = 2;
    localparam int CW   = $clog2(MAXV + 1);

    logic                clk_in = 1'b0;
    logic                rst_in;
    logic                start_in;
    logic [AB-1:0]       base_addr_in;
    logic [AB-1:0]       mem_addr_out;
    logic                mem_re_out;
    logic [2*W-1:0]      mem_data_in;
    logic signed [W-1:0] poly_xs_out [MAXV];
    logic signed [W-1:0] poly_ys_out [MAXV];
    logic [CW-1:0]       num_points_out;
    logic                valid_out;
    logic                busy_out;
    logic                done_out;
    logic                error_out;

    polygon_loader #(
        .WORLD_BITS(W), .MAX_NUM_VERTICES(MAXV), .ADDR_BITS(AB), .MEM_LATENCY(L)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .base_addr_in(base_addr_in),
        .mem_addr_out(mem_addr_out), .mem_re_out(mem_re_out), .mem_data_in(mem_data_in),
        .poly_xs_out(poly_xs_out), .poly_ys_out(poly_ys_out), .num_points_out(num_points_out),
        .valid_out(valid_out), .busy_out(busy_out), .done_out(done_out), .error_out(error_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Vertex memory with fixed read latency; junk on the bus when nothing was read.
    logic [2*W-1:0] mem [1 << AB];
    logic [2*W-1:0] pipe_d [L];
    always @(posedge clk_in) begin
        pipe_d[0] <= mem_re_out ? mem[mem_addr_out] : {$urandom, $urandom};
        for (int k = 1; k < L; k++) pipe_d[k] <= pipe_d[k-1];
    end
    assign mem_data_in = pipe_d[L-1];

    typedef struct packed { int cyc; logic [AB-1:0] addr; } rd_t;
    typedef struct packed { logic is_err; int cyc; logic [AB-1:0] base; logic [31:0] n; } ev_t;

    rd_t exp_rd [$];
    ev_t exp_ev [$];

    logic [W-1:0]  m_xs [MAXV];
    logic [W-1:0]  m_ys [MAXV];
    logic [CW-1:0] m_n;
    logic          m_valid;

    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic rst_pending = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < MAXV; i++) begin
            m_xs[i] = '0;
            m_ys[i] = '0;
        end
        m_n     = '0;
        m_valid = 1'b0;
    endfunction

    function automatic void model_commit(input logic [AB-1:0] b, input logic [31:0] n);
        for (int i = 0; i < MAXV; i++) begin
            if (i < int'(n)) begin
                m_xs[i] = mem[AB'(int'(b) + 1 + i)][2*W-1:W];
                m_ys[i] = mem[AB'(int'(b) + 1 + i)][W-1:0];
            end else begin
                m_xs[i] = '0;
                m_ys[i] = '0;
            end
        end
        m_n     = CW'(n);
        m_valid = 1'b1;
    endfunction

    // Reference: what a load started in cycle t0 must do, derived from the record format.
    function automatic void expect_load(input logic [AB-1:0] b, input int t0);
        logic [31:0] n;
        rd_t r;
        ev_t e;
        n = mem[b][W-1:0];
        r.cyc = t0 + 1;
        r.addr = b;
        exp_rd.push_back(r);
        e.base = b;
        e.n = n;
        if (n >= 3 && n <= MAXV) begin
            for (int k = 0; k < int'(n); k++) begin
                r.cyc  = t0 + L + 2 + k;
                r.addr = AB'(int'(b) + 1 + k);
                exp_rd.push_back(r);
            end
            e.is_err = 1'b0;
            e.cyc    = t0 + 2 * L + int'(n) + 2;
        end else begin
            e.is_err = 1'b1;
            e.cyc    = t0 + L + 2;
        end
        exp_ev.push_back(e);
    endfunction

    function automatic void write_header(input logic [AB-1:0] b, input logic [31:0] n);
        mem[b] = {$urandom, n};
    endfunction

    function automatic void set_vtx(input logic [AB-1:0] b, input int k, input int x, input int y);
        mem[AB'(int'(b) + 1 + k)] = {32'(x), 32'(y)};
    endfunction

    task automatic start_load(input logic [AB-1:0] b);
        start_in     = 1'b1;
        base_addr_in = b;
        expect_load(b, cyc);
        @(posedge clk_in); #1;
        start_in     = 1'b0;
        base_addr_in = AB'($urandom);
        check("busy_after_start", {63'b0, busy_out}, 64'd1);
    endtask

    // Stray start pulses while busy must be ignored; an accepted one shows up as extra reads.
    task automatic wait_idle();
        int k;
        k = 0;
        while (busy_out && k < 200) begin
            start_in     = ($urandom_range(0, 7) == 0);
            base_addr_in = AB'($urandom);
            @(posedge clk_in); #1;
            k++;
        end
        start_in = 1'b0;
        check("idle_within_bound", {63'b0, busy_out}, 64'd0);
    endtask

    initial begin : monitor
        rd_t        r;
        ev_t        e;
        int         bad;
        int         idx;
        logic [1:0] pulse;
        forever begin
            @(negedge clk_in);
            if (mon_en) begin
                if (rst_pending) begin
                    exp_rd.delete();
                    exp_ev.delete();
                    model_clear();
                end
                rst_pending = rst_in;

                if (mem_re_out) begin
                    if (exp_rd.size() == 0) begin
                        check("unexpected_read", {63'b0, mem_re_out}, 64'd0);
                    end else begin
                        r = exp_rd.pop_front();
                        check("read_addr", 64'(mem_addr_out), 64'(r.addr));
                        check("read_cycle", 64'(cyc), 64'(r.cyc));
                    end
                end else if (exp_rd.size() != 0 && exp_rd[0].cyc <= cyc) begin
                    r = exp_rd.pop_front();
                    check("read_enable", {63'b0, mem_re_out}, 64'd1);
                end

                pulse = {done_out, error_out};
                if (pulse != 2'b00) begin
                    if (exp_ev.size() == 0) begin
                        check("unexpected_pulse", 64'(pulse), 64'd0);
                    end else begin
                        e = exp_ev.pop_front();
                        check("event_kind", 64'(pulse), e.is_err ? 64'd1 : 64'd2);
                        check("event_cycle", 64'(cyc), 64'(e.cyc));
                        if (!e.is_err && pulse == 2'b10) model_commit(e.base, e.n);
                    end
                end else if (exp_ev.size() != 0 && exp_ev[0].cyc <= cyc) begin
                    e = exp_ev.pop_front();
                    check("event_pulse", 64'(pulse), e.is_err ? 64'd1 : 64'd2);
                end

                bad = -1;
                for (int i = 0; i < MAXV; i++)
                    if (bad < 0 && (poly_xs_out[i] !== m_xs[i] || poly_ys_out[i] !== m_ys[i])) bad = i;
                idx = (bad < 0) ? 0 : bad;
                check("out_x", {32'b0, poly_xs_out[idx]}, {32'b0, m_xs[idx]});
                check("out_y", {32'b0, poly_ys_out[idx]}, {32'b0, m_ys[idx]});
                check("out_num", 64'(num_points_out), 64'(m_n));
                check("out_valid", {63'b0, valid_out}, {63'b0, m_valid});
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : driver
        logic [AB-1:0] b;
        logic [31:0]   n;
        rst_in       = 1'b1;
        start_in     = 1'b0;
        base_addr_in = '0;
        for (int i = 0; i < (1 << AB); i++) mem[i] = {$urandom, $urandom};
        model_clear();
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;

        check("rst_mem_re", {63'b0, mem_re_out}, 64'd0);
        check("rst_mem_addr", 64'(mem_addr_out), 64'd0);
        check("rst_valid", {63'b0, valid_out}, 64'd0);
        check("rst_busy", {63'b0, busy_out}, 64'd0);
        check("rst_done", {63'b0, done_out}, 64'd0);
        check("rst_error", {63'b0, error_out}, 64'd0);
        check("rst_num", 64'(num_points_out), 64'd0);
        check("rst_x0", {32'b0, poly_xs_out[0]}, 64'd0);
        check("rst_y31", {32'b0, poly_ys_out[MAXV-1]}, 64'd0);
        mon_en = 1'b1;

        // Square at 0x010.
        write_header(10'h010, 4);
        set_vtx(10'h010, 0, 0, 0);
        set_vtx(10'h010, 1, 10, 0);
        set_vtx(10'h010, 2, 10, 10);
        set_vtx(10'h010, 3, 0, 10);
        start_load(10'h010);
        wait_idle();
        check("sq_num", 64'(num_points_out), 64'd4);
        check("sq_valid", {63'b0, valid_out}, 64'd1);
        check("sq_x1", {32'b0, poly_xs_out[1]}, 64'd10);
        check("sq_y2", {32'b0, poly_ys_out[2]}, 64'd10);
        check("sq_x4", {32'b0, poly_xs_out[4]}, 64'd0);

        // Rejected headers leave the square in place.
        write_header(10'h030, 2);
        start_load(10'h030);
        wait_idle();
        write_header(10'h040, 33);
        start_load(10'h040);
        wait_idle();
        check("err_keep_num", 64'(num_points_out), 64'd4);
        check("err_keep_x2", {32'b0, poly_xs_out[2]}, 64'd10);

        // Negative coordinates.
        write_header(10'h020, 3);
        set_vtx(10'h020, 0, -5, -7);
        set_vtx(10'h020, 1, 7, -1);
        set_vtx(10'h020, 2, 0, 9);
        start_load(10'h020);
        wait_idle();
        check("neg_x0", {32'b0, poly_xs_out[0]}, 64'h0000_0000_FFFF_FFFB);
        check("neg_y0", {32'b0, poly_ys_out[0]}, 64'h0000_0000_FFFF_FFF9);
        check("neg_num", 64'(num_points_out), 64'd3);

        // Record wrapping past the top of memory.
        write_header(10'h3FE, 3);
        for (int k = 0; k < 3; k++) set_vtx(10'h3FE, k, int'($urandom), int'($urandom));
        start_load(10'h3FE);
        wait_idle();
        check("wrap_x2", {32'b0, poly_xs_out[2]}, {32'b0, mem[10'h001][2*W-1:W]});

        // start_in in cycle 5 of an active load is ignored.
        write_header(10'h010, 4);
        start_load(10'h010);
        repeat (4) @(posedge clk_in);
        #1 start_in = 1'b1;
        base_addr_in = 10'h040;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        wait_idle();
        check("ign_num", 64'(num_points_out), 64'd4);

        // Reset in cycle 6 of a load aborts it and clears committed data.
        start_load(10'h020);
        repeat (5) @(posedge clk_in);
        #1 rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        check("mid_rst_busy", {63'b0, busy_out}, 64'd0);
        check("mid_rst_valid", {63'b0, valid_out}, 64'd0);
        check("mid_rst_num", 64'(num_points_out), 64'd0);
        check("mid_rst_x0", {32'b0, poly_xs_out[0]}, 64'd0);
        check("mid_rst_re", {63'b0, mem_re_out}, 64'd0);
        @(posedge clk_in); #1;
        start_load(10'h010);
        wait_idle();
        check("post_rst_num", 64'(num_points_out), 64'd4);

        // Randomized records, valid and invalid.
        for (int t = 0; t < 40; t++) begin
            b = AB'($urandom);
            if ($urandom_range(0, 9) < 7) begin
                n = 32'($urandom_range(3, MAXV));
            end else begin
                case ($urandom_range(0, 3))
                    0:       n = 32'($urandom_range(0, 2));
                    1:       n = 32'($urandom_range(MAXV + 1, MAXV + 8));
                    2:       n = 32'h8000_0004;
                    default: n = 32'hFFFF_FFFF;
                endcase
            end
            write_header(b, n);
            if (n >= 3 && n <= MAXV)
                for (int k = 0; k < int'(n); k++) set_vtx(b, k, int'($urandom), int'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk_in);
            #1 start_load(b);
            wait_idle();
        end

        repeat (5) @(posedge clk_in);
        #1;
        check("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
        check("ev_queue_empty", 64'(exp_ev.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
